// File: rtl/bus_data_validator_pkg.sv
// Shared types and constants for the bus data validator and its whitelist.
package bus_data_validator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_REPORT
    } state_t;

    localparam int unsigned DEF_WL_N = 4;

    localparam logic [31:0] DEF_WL [DEF_WL_N] = '{
        32'hFFFE0001,
        32'hFFFE0002,
        32'hFFFE0003,
        32'hFFFE0004
    };

    // Entries beyond the table continue the same numbering pattern.
    function automatic logic [31:0] default_entry(input int unsigned idx);
        logic [1:0] sel;
        sel = idx[1:0];
        if (idx < DEF_WL_N) begin
            return DEF_WL[sel];
        end
        return 32'hFFFE0001 + idx;
    endfunction

endpackage

// File: rtl/bus_data_validator_whitelist.sv
// Whitelist register file: DEPTH entries, each with an enable bit, one write
// port and one combinational read port addressed by the scan index.
module bdv_whitelist
    import bus_data_validator_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [DATA_W-1:0]        i_data,
    input  logic                     i_en,
    input  logic [$clog2(DEPTH)-1:0] i_rd_idx,
    output logic [DATA_W-1:0]        o_rd_data,
    output logic                     o_rd_en
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]  r_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= DATA_W'(default_entry(i));
                r_en[i]   <= 1'b1;
            end
        end else if (i_we) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_addr == IDX_W'(i)) begin
                    r_data[i] <= i_data;
                    r_en[i]   <= i_en;
                end
            end
        end
    end

    // Read is from the registers, so a write on the same edge is seen one cycle later.
    assign o_rd_data = r_data[i_rd_idx];
    assign o_rd_en   = r_en[i_rd_idx];

endmodule

// File: rtl/bus_data_validator.sv
// Bus data validator: latches a candidate word, scans the whitelist one entry
// per cycle, reports hit/miss with saturating totals, and drives the candidate on a tri-state bus.
module bus_data_validator
    import bus_data_validator_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     wl_we,
    input  logic [$clog2(DEPTH)-1:0] wl_addr,
    input  logic [DATA_W-1:0]        wl_data,
    input  logic                     wl_en,
    input  logic                     drive_en,
    output wire  [DATA_W-1:0]        bus,
    output logic                     chk_valid,
    output logic                     chk_hit,
    output logic [$clog2(DEPTH)-1:0] chk_index,
    output logic [CNT_W-1:0]         valid_cnt,
    output logic [CNT_W-1:0]         invalid_cnt,
    input  logic                     cnt_clr
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [DATA_W-1:0]  r_data_q;
    logic               r_hit;
    logic [IDX_W-1:0]   r_index;
    logic [CNT_W-1:0]   r_vcnt;
    logic [CNT_W-1:0]   r_icnt;
    logic [DATA_W-1:0]  w_wl_data;
    logic               w_wl_en;
    logic               w_accept;
    logic               w_match;
    logic               w_last;
    logic               w_report_hit;
    logic               w_report_miss;

    bdv_whitelist #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_whitelist (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_we      (wl_we),
        .i_addr    (wl_addr),
        .i_data    (wl_data),
        .i_en      (wl_en),
        .i_rd_idx  (r_idx),
        .o_rd_data (w_wl_data),
        .o_rd_en   (w_wl_en)
    );

    assign w_accept      = (r_state == ST_IDLE) && in_valid;
    assign w_match       = w_wl_en && (w_wl_data == r_data_q);
    assign w_last        = (r_idx == LAST_IDX);
    assign w_report_hit  = (r_state == ST_SCAN) && w_match;
    assign w_report_miss = (r_state == ST_SCAN) && !w_match && w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        chk_valid   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = ST_SCAN;
            end
            ST_SCAN: begin
                if (w_match || w_last) w_state_nxt = ST_REPORT;
            end
            ST_REPORT: begin
                chk_valid   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Scan index and result registers; the result is captured on the edge entering REPORT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx    <= '0;
            r_data_q <= '0;
            r_hit    <= 1'b0;
            r_index  <= '0;
        end else begin
            if (w_accept) begin
                r_data_q <= in_data;
                r_idx    <= '0;
            end else if ((r_state == ST_SCAN) && !w_match && !w_last) begin
                r_idx <= r_idx + 1'b1;
            end
            if (w_report_hit) begin
                r_hit   <= 1'b1;
                r_index <= r_idx;
            end else if (w_report_miss) begin
                r_hit   <= 1'b0;
                r_index <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vcnt <= '0;
            r_icnt <= '0;
        end else if (cnt_clr) begin
            r_vcnt <= '0;
            r_icnt <= '0;
        end else begin
            if (w_report_hit)  r_vcnt <= sat_inc(r_vcnt);
            if (w_report_miss) r_icnt <= sat_inc(r_icnt);
        end
    end

    assign chk_hit     = r_hit;
    assign chk_index   = r_index;
    assign valid_cnt   = r_vcnt;
    assign invalid_cnt = r_icnt;
    assign bus         = drive_en ? r_data_q : {DATA_W{1'bz}};

endmodule

// File: doc/bus_data_validator.md
BUS_DATA_VALIDATOR -- requirements
Module: bus_data_validator

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning data and bus width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, meaning number of whitelist entries (>=2).
REQ-003 SHALL have parameter CNT_W, default 16, meaning width of each result counter.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  candidate word offered.
REQ-007 in_ready  output  1  block can accept a candidate.
REQ-008 in_data  input  DATA_W  candidate word.
REQ-009 wl_we  input  1  whitelist write strobe.
REQ-010 wl_addr  input  $clog2(DEPTH)  whitelist entry index.
REQ-011 wl_data  input  DATA_W  whitelist entry value.
REQ-012 wl_en  input  1  enable bit written with the entry; disabled entries never match.
REQ-013 drive_en  input  1  enables bus driver.
REQ-014 bus  output  DATA_W  tri-state bus carrying the latched candidate.
REQ-015 chk_valid  output  1  one-cycle result strobe.
REQ-016 chk_hit  output  1  result: candidate matched an enabled entry.
REQ-017 chk_index  output  $clog2(DEPTH)  matching entry index; 0 on miss.
REQ-018 valid_cnt, invalid_cnt  output  CNT_W each  hit and miss totals.
REQ-019 cnt_clr  input  1  synchronous counter clear.

Function
REQ-020 SHALL implement FSM states IDLE, SCAN, REPORT.
REQ-021 in_ready SHALL be 1 only in IDLE; a candidate is accepted on a rising edge with in_valid && in_ready, latched into data_q, and the FSM SHALL move to SCAN with scan index 0.
REQ-022 In SCAN, each edge SHALL compare data_q with the entry at the scan index: enabled match -> REPORT with hit at that index; otherwise, if index == DEPTH-1 -> REPORT with miss; else index+1.
REQ-023 Latency: chk_valid SHALL be high in the cycle after k+1 edges following acceptance for a hit at entry k, and after DEPTH edges for a miss; the lowest matching index wins.
REQ-024 REPORT SHALL last exactly one cycle, with chk_valid=1, chk_hit and chk_index stable, then return to IDLE; chk_valid=0 in all other states.
REQ-025 chk_hit and chk_index SHALL hold their last value outside REPORT.
REQ-026 On the edge entering REPORT, valid_cnt (hit) or invalid_cnt (miss) SHALL increment, saturating at all ones.
REQ-027 cnt_clr SHALL zero both counters and take priority over a coincident increment.
REQ-028 A whitelist write SHALL update the entry on its edge; a scan comparing that entry on the same edge SHALL use the old value.
REQ-029 bus SHALL equal data_q when drive_en=1 and be all-Z otherwise, independent of FSM state.
REQ-030 in_data and in_valid SHALL be ignored outside IDLE.

Reset
REQ-031 rst_n low SHALL immediately force: state IDLE, scan index 0, data_q 0, chk_valid 0, chk_hit 0, chk_index 0, both counters 0, and in_ready 1 after release.
REQ-032 Reset SHALL load each whitelist entry from the package default table with enable=1.
REQ-033 Reset during SCAN or REPORT SHALL abort the check with no strobe and no count change.

Structure
REQ-034 The shared package SHALL hold the FSM state enum and the default whitelist constant {FFFE0001, FFFE0002, FFFE0003, FFFE0004} (hex, DATA_W=32, DEPTH=4).
REQ-035 The whitelist register file with its enable bits SHALL be one sub-module, bdv_whitelist.

Verification
REQ-036 After reset, offer FFFE0003 -> chk_valid 3 edges later, chk_hit=1, chk_index=2, valid_cnt=1.
REQ-037 Offer 12345678 -> chk_valid 4 edges later, chk_hit=0, chk_index=0, invalid_cnt=1.
REQ-038 Write entry 1 = 12345678 with wl_en=0, then offer 12345678 -> miss; rewrite with wl_en=1 -> hit at index 1.
REQ-039 Force invalid_cnt to all ones via CNT_W=2, then 4 misses -> saturates at 3; assert cnt_clr on a REPORT cycle -> counter reads 0.
REQ-040 drive_en=0 -> bus all Z; drive_en=1 after accepting FFFE0001 -> bus=FFFE0001; in_ready=0 during SCAN with in_valid held high.
REQ-041 Assert rst_n low mid-SCAN -> no chk_valid, counters 0, whitelist restored to defaults.
